// File: rtl/demux_latch_if.sv
// Producer/consumer bundle for the latching demultiplexer.
// Carries the offer handshake, channel registers, acks and drop counter.
interface demux_latch_if #(
    parameter int SELECT_WIDTH = 3,
    parameter int DATA_WIDTH   = 8
);
    localparam int N = 2 ** SELECT_WIDTH;

    logic                    in_valid;
    logic                    in_ready;
    logic [SELECT_WIDTH-1:0] select;
    logic [DATA_WIDTH-1:0]   data;
    logic [N*DATA_WIDTH-1:0] datas;
    logic [N-1:0]            valids;
    logic [N-1:0]            acks;
    logic [7:0]              drop_count;

    modport slave (
        input  in_valid,
        input  select,
        input  data,
        input  acks,
        output in_ready,
        output datas,
        output valids,
        output drop_count
    );

    modport master (
        output in_valid,
        output select,
        output data,
        output acks,
        input  in_ready,
        input  datas,
        input  valids,
        input  drop_count
    );
endinterface

// File: rtl/demux_latch.sv
// Latching demultiplexer: routes each accepted word to one of N channel
// registers, holds it until acked, and counts refused offers.
module demux_latch #(
    parameter int SELECT_WIDTH = 3,
    parameter int DATA_WIDTH   = 8
) (
    input logic           clk,
    input logic           rst_n,
    demux_latch_if.slave  bus
);
    localparam int N = 2 ** SELECT_WIDTH;

    logic [N*DATA_WIDTH-1:0] datas_q, datas_d;
    logic [N-1:0]            valids_q, valids_d;
    logic [7:0]              drop_count_q, drop_count_d;
    logic                    ready;
    logic                    accept;

    // Ready when the target channel is empty or being drained this cycle.
    always_comb begin
        ready  = rst_n & (!valids_q[bus.select] | bus.acks[bus.select]);
        accept = bus.in_valid & ready;
    end

    // Next-state: acks clear flags, an accept loads (and wins over an ack
    // on the same channel), a refusal bumps the saturating drop counter.
    always_comb begin
        datas_d      = datas_q;
        valids_d     = valids_q;
        drop_count_d = drop_count_q;
        for (int k = 0; k < N; k++) begin
            if (valids_q[k] && bus.acks[k]) begin
                valids_d[k] = 1'b0;
            end
        end
        if (accept) begin
            datas_d[int'(bus.select)*DATA_WIDTH +: DATA_WIDTH] = bus.data;
            valids_d[bus.select] = 1'b1;
        end
        if (bus.in_valid && !ready && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // State register with synchronous reset dominating all updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            datas_q      <= '0;
            valids_q     <= '0;
            drop_count_q <= '0;
        end else begin
            datas_q      <= datas_d;
            valids_q     <= valids_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.datas      = datas_q;
    assign bus.valids     = valids_q;
    assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_demux_latch.sv
// Scoreboard bench for demux_latch: the driver queues hand-computed
// expectations each cycle, the monitor checks them on the falling edge.
module tb_demux_latch;
    logic clk;
    logic rst_n;

    demux_latch_if #(.SELECT_WIDTH(3), .DATA_WIDTH(8)) bus ();

    demux_latch #(.SELECT_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 in_ready, 1 valids, 2 channel idx, 3 drop_count, 4 datas
    typedef struct {
        string       nm;
        int          kind;
        int          idx;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    task automatic expect_v(input string nm, input int kind,
                            input int idx, input logic [63:0] exp);
        exp_t e;
        e.nm   = nm;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Advance one cycle and apply new inputs shortly after the edge.
    task automatic drive(input logic rn, input logic v, input int sel,
                         input logic [7:0] d, input logic [7:0] a);
        @(posedge clk);
        #1;
        rst_n        = rn;
        bus.in_valid = v;
        bus.select   = sel[2:0];
        bus.data     = d;
        bus.acks     = a;
    endtask

    // Monitor: compare every queued expectation against the DUT.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = sb.pop_front();
            act = '0;
            unique case (e.kind)
                0: act = {63'd0, bus.in_ready};
                1: act = {56'd0, bus.valids};
                2: act = {56'd0, bus.datas[e.idx*8 +: 8]};
                3: act = {56'd0, bus.drop_count};
                default: act = bus.datas;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.nm, act, e.exp);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.select   = '0;
        bus.data     = '0;
        bus.acks     = '0;

        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        expect_v("rst_ready", 0, 0, 64'd0);

        // Reset state, then fill channel k with k.
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, k, k[7:0], 8'h00);
            if (k == 0) begin
                expect_v("rst_valids", 1, 0, 64'h0);
                expect_v("rst_datas", 4, 0, 64'h0);
                expect_v("rst_drop", 3, 0, 64'h0);
            end
            expect_v("fill_ready", 0, 0, 64'd1);
            expect_v("fill_valids", 1, 0, 64'((1 << k) - 1));
        end
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("fill_valids_ff", 1, 0, 64'hFF);
        expect_v("fill_drop", 3, 0, 64'h0);
        expect_v("fill_datas", 4, 0, 64'h0706050403020100);

        // Backpressure on a full channel.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5, 8'hAA, 8'h00);
            expect_v("bp_ready", 0, 0, 64'd0);
        end
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("bp_ch5", 2, 5, 64'h05);
        expect_v("bp_drop", 3, 0, 64'd3);

        // Ack and refill in the same cycle.
        drive(1, 1, 5, 8'h55, 8'h20);
        expect_v("refill_ready", 0, 0, 64'd1);
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("refill_valids", 1, 0, 64'hFF);
        expect_v("refill_ch5", 2, 5, 64'h55);
        expect_v("refill_drop", 3, 0, 64'd3);

        // Drain channel 2, then a second ack with nothing held.
        drive(1, 0, 0, 8'h00, 8'h04);
        drive(1, 0, 0, 8'h00, 8'h04);
        expect_v("drain_valids", 1, 0, 64'hFB);
        expect_v("drain_ch2", 2, 2, 64'h02);
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("drain2_valids", 1, 0, 64'hFB);
        expect_v("drain2_ch2", 2, 2, 64'h02);

        // Multiple acks alongside an accept to another channel.
        drive(1, 1, 2, 8'h22, 8'h03);
        expect_v("multi_ready", 0, 0, 64'd1);
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("multi_valids", 1, 0, 64'hFC);
        expect_v("multi_datas", 4, 0, 64'h0706550403220100);

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 7, 8'hEE, 8'h00);
            if (i == 0) expect_v("sat_ready", 0, 0, 64'd0);
        end
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("sat_drop", 3, 0, 64'd255);
        expect_v("sat_ch7", 2, 7, 64'h07);
        for (int i = 0; i < 5; i++) drive(1, 1, 6, 8'hEE, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("sat_hold", 3, 0, 64'd255);

        // Mid-operation reset with offer and acks asserted.
        drive(0, 1, 3, 8'h99, 8'hFF);
        expect_v("mrst_ready", 0, 0, 64'd0);
        drive(1, 0, 0, 8'h00, 8'h00);
        expect_v("mrst_valids", 1, 0, 64'h0);
        expect_v("mrst_datas", 4, 0, 64'h0);
        expect_v("mrst_drop", 3, 0, 64'h0);

        drive(1, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/demux_latch.md
DEMUX_LATCH -- requirements
Module: demux_latch

Interface
REQ-001 The block SHALL have parameter SELECT_WIDTH, default 3, giving the channel-select width; N = 2**SELECT_WIDTH channels.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each channel word.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  producer offers a word this cycle.
REQ-006 The block SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-007 The block SHALL have port select  input  SELECT_WIDTH  destination channel index of the offered word.
REQ-008 The block SHALL have port data  input  DATA_WIDTH  offered word.
REQ-009 The block SHALL have port datas  output  N*DATA_WIDTH  packed channel registers; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port valids  output  N  per-channel "holding unconsumed word" flags; bit k belongs to channel k.
REQ-011 The block SHALL have port acks  input  N  per-channel consumer acknowledge; bit k acknowledges channel k.
REQ-012 The block SHALL have port drop_count  output  8  saturating count of refused offers.

Function
REQ-013 in_ready SHALL be combinational: (!valids[select] | acks[select]) while rst_n=1; it SHALL be 0 while rst_n=0.
REQ-014 An offer SHALL be accepted when in_valid=1 and in_ready=1 on a rising edge.
REQ-015 On accept, channel[select] SHALL load data and valids[select] SHALL be 1 from the next cycle (latency 1).
REQ-016 When acks[k]=1, valids[k]=1 and there is no accept to k, valids[k] SHALL clear next cycle; channel k data SHALL be retained.
REQ-017 acks[k]=1 with valids[k]=0 SHALL be ignored.
REQ-018 Simultaneous ack and accept on the same channel: valids SHALL stay 1 and data SHALL be replaced with the new word.
REQ-019 Acks to multiple channels in one cycle SHALL all take effect independently, alongside any accept to a different channel.
REQ-020 Channels not accepted into and not acked SHALL hold data and valid unchanged.
REQ-021 A refused offer (in_valid=1, in_ready=0, rst_n=1) SHALL increment drop_count by 1, saturating at 255.
REQ-022 drop_count SHALL be cleared only by reset.
REQ-023 A refused offer SHALL not modify any channel.
REQ-024 When in_valid=0, select and data SHALL be don't-care.

Reset
REQ-025 With rst_n=0 at a rising edge, all datas bits, all valids and drop_count SHALL be 0 from the next cycle.
REQ-026 Reset SHALL dominate simultaneous accepts and acks; no capture SHALL occur in a reset cycle, including mid-operation.
REQ-027 No state SHALL change asynchronously to clk.

Verification (SELECT_WIDTH=3, DATA_WIDTH=8)
REQ-028 Fill test: after reset, offer data=k to select=k for k=0..7 on consecutive cycles, acks=0 -> in_ready=1 every cycle; valids steps 0x01,0x03,...,0xFF; channel k reads k; drop_count=0.
REQ-029 Backpressure test: channel 5 holds 0x05; offer 0xAA to select=5 for 3 cycles, acks=0 -> in_ready=0; channel 5 stays 0x05; drop_count=3.
REQ-030 Ack-and-refill test: acks[5]=1 and offer 0x55 to select=5 in the same cycle -> in_ready=1; next cycle valids[5]=1 and channel 5=0x55.
REQ-031 Drain test: acks[2]=1 alone -> next cycle valids[2]=0 and channel 2 still 0x02; a second acks[2] pulse -> no change.
REQ-032 Saturation test: 300 consecutive refused offers -> drop_count=255 and holds 255.
REQ-033 Mid-operation reset test: rst_n=0 with in_valid=1 and acks=0xFF -> in_ready=0; next cycle valids=0x00, datas all 0, drop_count=0.
